c7bexu_byplog_mp: RTL and testbench



---
 rtl/c7bexu_pkg.sv | 16 +
 rtl/c7bexu_byp_src.sv | 47 ++++
 rtl/c7bexu_byplog_mp.sv | 115 +++++++++++
 tb/tb_c7bexu_byplog_mp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/c7bexu_pkg.sv
// Shared definitions for the EXU bypass/interlock logic.
package c7bexu_pkg;

    localparam int REGW_DFLT = 5;

    typedef logic [REGW_DFLT-1:0] reg_idx_t;

    // Select bit positions: bit 0 is the register file, bit k is pipeline stage k.
    localparam int SEL_RF = 0;
    localparam int SEL_M  = 1;

    function automatic logic idx_live(input logic [REGW_DFLT-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/c7bexu_byp_src.sv
// Per-operand forwarding select: nearest-stage priority with load-data blocking.
module c7bexu_byp_src
    import c7bexu_pkg::*;
#(
    parameter int NSTG   = 2,
    parameter int REGW   = REGW_DFLT,
    parameter int LD_STG = 2
) (
    input  logic [REGW-1:0]      rs,
    input  logic                 rs_vld,
    input  logic [NSTG-1:0]      stg_wen,
    input  logic [NSTG-1:0]      stg_ld,
    input  logic [NSTG*REGW-1:0] stg_rd,
    output logic [NSTG:0]        sel,
    output logic                 ld_hit
);

    logic [NSTG-1:0] hit;
    logic            found;

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            hit[k] = rs_vld & (rs != '0) & stg_wen[k] & (rs == stg_rd[k*REGW +: REGW]);
        end
    end

    // Only the nearest hit may drive the select; a too-young load there forces RF
    // (the stall keeps that value from ever being consumed).
    always_comb begin
        sel    = '0;
        ld_hit = 1'b0;
        found  = 1'b0;
        for (int k = 1; k <= NSTG; k++) begin
            if (hit[k-1] && stg_ld[k-1] && (k < LD_STG)) begin
                ld_hit = 1'b1;
            end
            if (hit[k-1] && !found) begin
                found = 1'b1;
                if (!(stg_ld[k-1] && (k < LD_STG))) begin
                    sel[k] = 1'b1;
                end
            end
        end
        sel[SEL_RF] = ~|sel[NSTG:1];
    end

endmodule

// File: rtl/c7bexu_byplog_mp.sv
// Execute-stage bypass selector for NSRC operands with load-use interlock
// and a long-latency pending-register scoreboard.
module c7bexu_byplog_mp
    import c7bexu_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int NSTG   = 2,
    parameter int REGW   = REGW_DFLT,
    parameter int LD_STG = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC*REGW-1:0]   rs_e,
    input  logic [NSRC-1:0]        rs_vld_e,
    input  logic                   valid_e,
    input  logic [REGW-1:0]        rd_e,
    input  logic                   wen_e,
    input  logic                   ld_e,
    input  logic                   lng_e,
    input  logic                   lng_wb_vld,
    input  logic [REGW-1:0]        lng_wb_rd,
    input  logic                   flush,
    output logic [NSRC*(NSTG+1)-1:0] sel,
    output logic                   stall_e
);

    localparam int NREG = 2**REGW;

    logic [NSTG-1:0]      stg_wen;
    logic [NSTG-1:0]      stg_ld;
    logic [NSTG*REGW-1:0] stg_rd;
    logic [NREG-1:0]      pending;

    logic [NSRC-1:0] src_ld_hit;
    logic [NSRC-1:0] src_sb_hit;
    logic            ld_hit;
    logic            sb_hit;
    logic            waw;
    logic            lng_order;
    logic            adv;
    logic            pend_set;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        c7bexu_byp_src #(
            .NSTG   (NSTG),
            .REGW   (REGW),
            .LD_STG (LD_STG)
        ) u_src (
            .rs      (rs_e[i*REGW +: REGW]),
            .rs_vld  (rs_vld_e[i]),
            .stg_wen (stg_wen),
            .stg_ld  (stg_ld),
            .stg_rd  (stg_rd),
            .sel     (sel[i*(NSTG+1) +: NSTG+1]),
            .ld_hit  (src_ld_hit[i])
        );

        assign src_sb_hit[i] = rs_vld_e[i] & (rs_e[i*REGW +: REGW] != '0)
                             & pending[rs_e[i*REGW +: REGW]];
    end

    assign ld_hit = |src_ld_hit;
    assign sb_hit = |src_sb_hit;
    assign waw    = (wen_e | lng_e) & (rd_e != '0) & pending[rd_e];

    // A long op must not overtake an in-flight normal write to the same register.
    always_comb begin
        lng_order = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            if (stg_wen[k] && (stg_rd[k*REGW +: REGW] == rd_e)) begin
                lng_order = 1'b1;
            end
        end
        lng_order = lng_order & lng_e & (rd_e != '0);
    end

    assign stall_e  = valid_e & (ld_hit | sb_hit | waw | lng_order);
    assign adv      = valid_e & ~stall_e;
    assign pend_set = adv & lng_e & (rd_e != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_wen <= '0;
            stg_ld  <= '0;
            stg_rd  <= '0;
        end else begin
            stg_wen[0]        <= adv & wen_e & ~lng_e & ~flush;
            stg_ld[0]         <= adv & ld_e;
            stg_rd[REGW-1:0]  <= adv ? rd_e : '0;
            for (int k = 1; k < NSTG; k++) begin
                stg_wen[k]               <= stg_wen[k-1] & ~flush;
                stg_ld[k]                <= stg_ld[k-1];
                stg_rd[k*REGW +: REGW]   <= stg_rd[(k-1)*REGW +: REGW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (pend_set) begin
                pending[rd_e] <= 1'b1;
            end
            if (lng_wb_vld) begin
                pending[lng_wb_rd] <= 1'b0;
            end
        end
    end

    a_no_set_clr_same: assert property (@(posedge clk) disable iff (reset)
        !(pend_set && lng_wb_vld && (lng_wb_rd == rd_e)))
        else $error("pending set and clear collide on r%0d", rd_e);

endmodule

// File: tb/tb_c7bexu_byplog_mp.sv
// Directed bench for c7bexu_byplog_mp (NSRC=2, NSTG=2, REGW=5, LD_STG=2).
module tb_c7bexu_byplog_mp;

    logic        clk;
    logic        reset;
    logic [9:0]  rs_e;
    logic [1:0]  rs_vld_e;
    logic        valid_e;
    logic [4:0]  rd_e;
    logic        wen_e;
    logic        ld_e;
    logic        lng_e;
    logic        lng_wb_vld;
    logic [4:0]  lng_wb_rd;
    logic        flush;
    logic [5:0]  sel;
    logic        stall_e;

    int checks = 0;
    int errors = 0;

    c7bexu_byplog_mp #(.NSRC(2), .NSTG(2), .REGW(5), .LD_STG(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_e       (rs_e),
        .rs_vld_e   (rs_vld_e),
        .valid_e    (valid_e),
        .rd_e       (rd_e),
        .wen_e      (wen_e),
        .ld_e       (ld_e),
        .lng_e      (lng_e),
        .lng_wb_vld (lng_wb_vld),
        .lng_wb_rd  (lng_wb_rd),
        .flush      (flush),
        .sel        (sel),
        .stall_e    (stall_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the E-stage instruction: sources, read-valids, dest and kind.
    task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] vld, input logic [4:0] rd,
                         input logic wen, input logic ld, input logic lng);
        valid_e  = v;
        rs_e     = {rs1, rs0};
        rs_vld_e = vld;
        rd_e     = rd;
        wen_e    = wen;
        ld_e     = ld;
        lng_e    = lng;
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        lng_wb_vld = 1'b0;
        lng_wb_rd = 5'd0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_sel", sel, 6'b001001);
        chk("reset_stall", {5'd0, stall_e}, 6'd0);

        // 1: plain read, no writers
        drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t1_sel", sel, 6'b001001);
        chk("t1_stall", {5'd0, stall_e}, 6'd0);

        // 2: ALU r5 forwarded from stage 1 then stage 2
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_stg1", sel, 6'b001010);
        tick();
        chk("t2_stg2", sel, 6'b001100);
        drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_both", sel, 6'b100100);
        drain();

        // 3: load-use on operand 1
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t3_stall", {5'd0, stall_e}, 6'd1);
        chk("t3_sel_blk", sel, 6'b001001);
        tick();
        chk("t3_stall_rel", {5'd0, stall_e}, 6'd0);
        chk("t3_sel_stg2", sel, 6'b100001);
        drain();

        // 4: nearest writer wins; r0 and unread operands ignored
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t4_nearest", sel, 6'b001010);
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t4_r0", sel, 6'b001001);
        drive(1'b1, 5'd9, 5'd9, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t4_novld", sel, 6'b001001);
        drain();

        // 5: long-latency r12 scoreboard, WAW, ordering
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, 1'b0, 1'b1);
        chk("t5_issue", {5'd0, stall_e}, 6'd0);
        tick();
        drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t5_sb_stall", {5'd0, stall_e}, 6'd1);
        tick();
        chk("t5_sb_hold", {5'd0, stall_e}, 6'd1);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("t5_waw", {5'd0, stall_e}, 6'd1);
        drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        lng_wb_vld = 1'b1;
        lng_wb_rd  = 5'd12;
        #1;
        chk("t5_wb_cycle", {5'd0, stall_e}, 6'd1);
        tick();
        lng_wb_vld = 1'b0;
        #1;
        chk("t5_after_wb", {5'd0, stall_e}, 6'd0);
        chk("t5_sel_rf", sel, 6'b001001);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd20, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd20, 1'b0, 1'b0, 1'b1);
        chk("t5_lng_order", {5'd0, stall_e}, 6'd1);
        drain();

        // 6: flush kills writers next cycle, not this one
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("t6_flush_same", sel, 6'b001010);
        tick();
        flush = 1'b0;
        #1;
        chk("t6_flush_next", sel, 6'b001001);
        drain();

        // reset in the middle of a scoreboard stall
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_rst", {5'd0, stall_e}, 6'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_async", {5'd0, stall_e}, 6'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_rst_clear", {5'd0, stall_e}, 6'd0);
        chk("t6_rst_sel", sel, 6'b001001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
